// File: rtl/aes_pkg.sv
// Shared AES byte type and the forward/inverse S-box tables used by the SubBytes datapath.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_dual.sv
// Single-byte combinational S-box with per-lookup forward/inverse selection.
module aes_sbox_dual
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = 8'h00;
    if (inv_i) begin
      data_o = INV_SBOX[data_i];
    end else begin
      data_o = SBOX[data_i];
    end
  end

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// Two-stage valid/ready SubBytes/InvSubBytes engine: S1 captures the input, S2 holds the
// substituted bytes; both stages advance independently so a stalled output still admits one more input.
module aes_sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 16,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_inv,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_inv,
  output logic [TAG_W-1:0]     out_tag,
  output logic [CNT_W-1:0]     xfer_cnt
);

  localparam int unsigned DW = 8 * LANES;

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_data_q, s1_data_d;
  logic             s1_inv_q, s1_inv_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [DW-1:0]    s2_data_q, s2_data_d;
  logic             s2_inv_q, s2_inv_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DW-1:0]    sub_data;
  logic             s1_load;
  logic             s2_load;
  logic             out_xfer;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_dual u_sbox (
      .data_i (s1_data_q[8*g +: 8]),
      .inv_i  (s1_inv_q),
      .data_o (sub_data[8*g +: 8])
    );
  end

  // in_ready sees out_ready through s2_load only; held high while in reset.
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !rst_n || !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign out_xfer = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_load | (s1_valid_q & ~s2_load);
    s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
    s1_data_d  = s1_data_q;
    s1_inv_d   = s1_inv_q;
    s1_tag_d   = s1_tag_q;
    s2_data_d  = s2_data_q;
    s2_inv_d   = s2_inv_q;
    s2_tag_d   = s2_tag_q;
    cnt_d      = cnt_q;
    if (s1_load) begin
      s1_data_d = in_data;
      s1_inv_d  = in_inv;
      s1_tag_d  = in_tag;
    end else begin
      s1_data_d = s1_data_q;
    end
    if (s2_load) begin
      s2_data_d = sub_data;
      s2_inv_d  = s1_inv_q;
      s2_tag_d  = s1_tag_q;
    end else begin
      s2_data_d = s2_data_q;
    end
    if (out_xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_inv_q   <= 1'b0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_inv_q   <= 1'b0;
      s2_tag_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_inv_q   <= s1_inv_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_inv_q   <= s2_inv_d;
      s2_tag_q   <= s2_tag_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_inv   = s2_inv_q;
  assign out_tag   = s2_tag_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Bench for aes_sub_bytes_pipe: S-box reference derived from GF(2^8) inversion plus the affine map,
// a transaction scoreboard, directed scenarios and a randomized phase.
module tb_aes_sub_bytes_pipe;

  localparam int LANES = 16;
  localparam int DW    = 8 * LANES;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_inv;
  logic [3:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_inv;
  logic [3:0]    out_tag;
  logic [15:0]   xfer_cnt;

  logic          in_ready2, out_valid2, out_inv2;
  logic [31:0]   out_data2;
  logic [3:0]    out_tag2;
  logic [1:0]    xfer_cnt2;

  always #5 clk = ~clk;

  aes_sub_bytes_pipe #(.LANES(LANES), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_inv(out_inv), .out_tag(out_tag), .xfer_cnt(xfer_cnt)
  );

  // Narrow-counter instance sharing the same handshake stimulus.
  aes_sub_bytes_pipe #(.LANES(4), .TAG_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data[31:0]),
    .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_inv(out_inv2), .out_tag(out_tag2), .xfer_cnt(xfer_cnt2)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          inv;
    logic [3:0]    tag;
  } exp_t;

  logic [7:0]  fwd_ref [256];
  logic [7:0]  inv_ref [256];
  exp_t        exp_q [$];
  logic [15:0] mcnt;
  logic        stall_prev;
  logic [DW-1:0] prev_data;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [DW-1:0] ref_sub(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = inv ? inv_ref[d[8*i +: 8]] : fwd_ref[d[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", DW'(exp_q.size()), '0);
  endtask

  // Scoreboard: observe handshakes mid-cycle, before the edge that commits them.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mcnt       = 16'h0000;
      stall_prev = 1'b0;
    end else begin
      exp_t e;
      check("xfer_cnt", DW'(xfer_cnt), DW'(mcnt));
      check("in_ready_occ", DW'(in_ready), DW'((exp_q.size() < 2) || out_ready));
      if (exp_q.size() == 0) check("idle_out_valid", DW'(out_valid), '0);
      if (exp_q.size() == 2) check("full_out_valid", DW'(out_valid), DW'(1));
      if (stall_prev) begin
        check("stall_valid", DW'(out_valid), DW'(1));
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", DW'(out_valid), '0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_inv", DW'(out_inv), DW'(e.inv));
          check("out_tag", DW'(out_tag), DW'(e.tag));
        end
        mcnt = mcnt + 16'h0001;
      end
      if (in_valid && in_ready) begin
        e.d   = ref_sub(in_data, in_inv);
        e.inv = in_inv;
        e.tag = in_tag;
        exp_q.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    logic [7:0]  r;
    logic [7:0]  b;
    logic [15:0] cnt0;

    for (int x = 0; x < 256; x++) begin
      r = 8'h01;
      for (int k = 0; k < 254; k++) r = gmul(r, 8'(x));
      b = r;
      fwd_ref[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_ref[fwd_ref[x]] = 8'(x);

    in_data   = '0;
    in_inv    = 1'b0;
    in_tag    = 4'h0;
    out_ready = 1'b1;
    do_reset();
    tick();
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_inv", DW'(out_inv), '0);
    check("rst_out_tag", DW'(out_tag), '0);
    check("rst_xfer_cnt", DW'(xfer_cnt), '0);
    check("rst_in_ready", DW'(in_ready), DW'(1));

    // Forward single transaction with the spec's reference bytes.
    in_data  = {96'h0, 32'hFF015300};
    in_inv   = 1'b0;
    in_tag   = 4'h5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("fwd_valid", DW'(out_valid), DW'(1));
    check("fwd_lanes", DW'(out_data[31:0]), DW'(32'h167CED63));
    check("fwd_tag", DW'(out_tag), DW'(4'h5));
    tick();
    check("fwd_cnt", DW'(xfer_cnt), DW'(1));

    // Inverse round trip.
    in_data  = {96'h0, 32'h167CED63};
    in_inv   = 1'b1;
    in_tag   = 4'hA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("inv_valid", DW'(out_valid), DW'(1));
    check("inv_lanes", DW'(out_data[31:0]), DW'(32'hFF015300));
    check("inv_inv", DW'(out_inv), DW'(1));
    tick();
    check("inv_cnt", DW'(xfer_cnt), DW'(2));

    // Exhaustive sweep, both modes back to back; lanes carry rotated copies of the index.
    do_reset();
    out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 256; k++) begin
        for (int i = 0; i < LANES; i++) in_data[8*i +: 8] = 8'(k + 37 * i);
        in_inv   = m[0];
        in_tag   = 4'(k);
        in_valid = 1'b1;
        tick();
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("sweep_cnt", DW'(xfer_cnt), DW'(512));
    check("sweep_drained", DW'(out_valid), '0);

    // Backpressure: three inputs against a stalled output.
    cnt0      = xfer_cnt;
    out_ready = 1'b0;
    in_inv    = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    in_tag    = 4'h1;
    tick();
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_tag  = 4'h2;
    tick();
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_tag  = 4'h3;
    check("bp_in_ready_low", DW'(in_ready), '0);
    tick();
    tick();
    tick();
    check("bp_held_ready", DW'(in_ready), '0);
    check("bp_held_tag", DW'(out_tag), DW'(4'h1));
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", DW'(in_ready), DW'(1));
    tick();
    in_valid = 1'b0;
    drain();
    check("bp_cnt", DW'(xfer_cnt - cnt0), DW'(3));

    // Five transfers: the 2-bit counter wraps to 1.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("cnt5_wide", DW'(xfer_cnt), DW'(5));
    check("cnt5_narrow", DW'(xfer_cnt2), DW'(1));

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 1'b0;
    check("flight_full", DW'(out_valid), DW'(1));
    rst_n = 1'b0;
    tick();
    check("flight_rst_valid", DW'(out_valid), '0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("flight_after_valid", DW'(out_valid), '0);
    check("flight_after_cnt", DW'(xfer_cnt), '0);

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_inv    = 1'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_final_cnt", DW'(xfer_cnt), DW'(mcnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
